// File: rtl/sram_slave_wrapper_pkg.sv
// Shared types and constants for the AXI-to-SRAM slave endpoint.
package sram_slave_wrapper_pkg;

   // AXI channel widths
   localparam int unsigned AXI_IDS_BITS  = 8;
   localparam int unsigned AXI_ADDR_BITS = 32;
   localparam int unsigned AXI_LEN_BITS  = 4;
   localparam int unsigned AXI_SIZE_BITS = 3;
   localparam int unsigned AXI_DATA_BITS = 32;
   localparam int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8;

   // Response and burst encodings
   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;
   localparam logic [1:0] AXI_BURST_INC = 2'b01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RDATA = 2'd1,
      WDATA = 2'd2,
      WRESP = 2'd3
   } state_e;

   // Per-transaction attributes held for the duration of a burst
   typedef struct packed {
      logic [AXI_IDS_BITS-1:0] id;
      logic [AXI_LEN_BITS-1:0] len;
   } txn_t;

   // Expand byte strobes into an active-low per-bit SRAM write mask
   function automatic logic [AXI_DATA_BITS-1:0] strb_to_bweb(
      input logic [AXI_STRB_BITS-1:0] strb);
      logic [AXI_DATA_BITS-1:0] bweb;
      bweb = '1;
      for (int k = 0; k < int'(AXI_STRB_BITS); k++) begin
         bweb[8*k +: 8] = {8{~strb[k]}};
      end
      return bweb;
   endfunction

endpackage

// File: rtl/sram_slave_wrapper_if.sv
// AXI4 slave-side channel bundle (AW, W, B, AR, R).
interface sram_slave_wrapper_if;
   import sram_slave_wrapper_pkg::*;

   // write address channel
   logic [AXI_IDS_BITS-1:0]  S_AWID;
   logic [AXI_ADDR_BITS-1:0] S_AWAddr;
   logic [AXI_LEN_BITS-1:0]  S_AWLen;
   logic [AXI_SIZE_BITS-1:0] S_AWSize;
   logic [1:0]               S_AWBurst;
   logic                     S_AWValid;
   logic                     S_AWReady;

   // write data channel
   logic [AXI_DATA_BITS-1:0] S_WData;
   logic [AXI_STRB_BITS-1:0] S_WStrb;
   logic                     S_WLast;
   logic                     S_WValid;
   logic                     S_WReady;

   // write response channel
   logic [AXI_IDS_BITS-1:0]  S_BID;
   logic [1:0]               S_BResp;
   logic                     S_BValid;
   logic                     S_BReady;

   // read address channel
   logic [AXI_IDS_BITS-1:0]  S_ARID;
   logic [AXI_ADDR_BITS-1:0] S_ARAddr;
   logic [AXI_LEN_BITS-1:0]  S_ARLen;
   logic [AXI_SIZE_BITS-1:0] S_ARSize;
   logic [1:0]               S_ARBurst;
   logic                     S_ARValid;
   logic                     S_ARReady;

   // read data channel
   logic [AXI_IDS_BITS-1:0]  S_RID;
   logic [AXI_DATA_BITS-1:0] S_RData;
   logic [1:0]               S_RResp;
   logic                     S_RLast;
   logic                     S_RValid;
   logic                     S_RReady;

   modport slave (
      input  S_AWID, S_AWAddr, S_AWLen, S_AWSize, S_AWBurst, S_AWValid,
      output S_AWReady,
      input  S_WData, S_WStrb, S_WLast, S_WValid,
      output S_WReady,
      output S_BID, S_BResp, S_BValid,
      input  S_BReady,
      input  S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst, S_ARValid,
      output S_ARReady,
      output S_RID, S_RData, S_RResp, S_RLast, S_RValid,
      input  S_RReady
   );

   modport master (
      output S_AWID, S_AWAddr, S_AWLen, S_AWSize, S_AWBurst, S_AWValid,
      input  S_AWReady,
      output S_WData, S_WStrb, S_WLast, S_WValid,
      input  S_WReady,
      input  S_BID, S_BResp, S_BValid,
      output S_BReady,
      output S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst, S_ARValid,
      input  S_ARReady,
      input  S_RID, S_RData, S_RResp, S_RLast, S_RValid,
      output S_RReady
   );

endinterface

// File: rtl/sram_slave_wrapper.sv
// AXI4 slave endpoint: one INCR burst at a time onto a 1-cycle-latency
// single-port SRAM. Reads re-issue the current word during R stalls so
// no read-data buffer is needed.
module sram_slave_wrapper
   import sram_slave_wrapper_pkg::*;
#(
   parameter int unsigned SRAM_ADDR_BITS = 14
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   sram_slave_wrapper_if.slave       s,
   output logic                      SRAM_CEB,
   output logic                      SRAM_WEB,
   output logic [AXI_DATA_BITS-1:0]  SRAM_BWEB,
   output logic [SRAM_ADDR_BITS-1:0] SRAM_A,
   output logic [AXI_DATA_BITS-1:0]  SRAM_DI,
   input  logic [AXI_DATA_BITS-1:0]  SRAM_DO
);

   state_e                    state_q, state_d;
   txn_t                      txn_q, txn_d;
   logic [SRAM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [AXI_LEN_BITS-1:0]   beat_q, beat_d;
   logic                      err_q, err_d;

   logic [SRAM_ADDR_BITS-1:0] ar_word;
   logic [SRAM_ADDR_BITS-1:0] aw_word;
   logic [SRAM_ADDR_BITS-1:0] addr_inc;
   logic                      last_beat;
   logic                      unused_ok;

   assign ar_word   = s.S_ARAddr[SRAM_ADDR_BITS+1:2];
   assign aw_word   = s.S_AWAddr[SRAM_ADDR_BITS+1:2];
   assign addr_inc  = addr_q + 1'b1;
   assign last_beat = (beat_q == txn_q.len);

   // Size/burst are fixed (32-bit INCR); address bits outside the word field are dropped
   assign unused_ok = ^{s.S_AWSize, s.S_AWBurst, s.S_ARSize, s.S_ARBurst,
                        s.S_AWAddr, s.S_ARAddr};

   // State and burst-tracking registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         txn_q   <= '0;
         addr_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         txn_q   <= txn_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   // Next-state, bus handshakes and SRAM control
   always_comb begin
      state_d     = state_q;
      txn_d       = txn_q;
      addr_d      = addr_q;
      beat_d      = beat_q;
      err_d       = err_q;

      s.S_AWReady = 1'b0;
      s.S_WReady  = 1'b0;
      s.S_BID     = '0;
      s.S_BResp   = RESP_OKAY;
      s.S_BValid  = 1'b0;
      s.S_ARReady = 1'b0;
      s.S_RID     = '0;
      s.S_RData   = '0;
      s.S_RResp   = RESP_OKAY;
      s.S_RLast   = 1'b0;
      s.S_RValid  = 1'b0;

      SRAM_CEB    = 1'b1;
      SRAM_WEB    = 1'b1;
      SRAM_BWEB   = '1;
      SRAM_A      = addr_q;
      SRAM_DI     = '0;

      unique case (state_q)
         IDLE: begin
            // readies held low while reset is asserted; reads win over writes
            s.S_ARReady = ARESETn;
            s.S_AWReady = ARESETn & ~s.S_ARValid;
            if (s.S_ARValid && s.S_ARReady) begin
               txn_d.id  = s.S_ARID;
               txn_d.len = s.S_ARLen;
               addr_d    = ar_word;
               beat_d    = '0;
               // first word is fetched now so data is ready on the next cycle
               SRAM_CEB  = 1'b0;
               SRAM_A    = ar_word;
               state_d   = RDATA;
            end else if (s.S_AWValid && s.S_AWReady) begin
               txn_d.id  = s.S_AWID;
               txn_d.len = s.S_AWLen;
               addr_d    = aw_word;
               beat_d    = '0;
               err_d     = 1'b0;
               state_d   = WDATA;
            end
         end

         RDATA: begin
            SRAM_CEB   = 1'b0;
            s.S_RValid = 1'b1;
            s.S_RData  = SRAM_DO;
            s.S_RID    = txn_q.id;
            s.S_RLast  = last_beat;
            if (s.S_RReady) begin
               // fetch the next word; on a stall the current word is re-read
               SRAM_A = addr_inc;
               addr_d = addr_inc;
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
               end
            end
         end

         WDATA: begin
            s.S_WReady = 1'b1;
            if (s.S_WValid) begin
               SRAM_CEB  = 1'b0;
               SRAM_WEB  = 1'b0;
               SRAM_DI   = s.S_WData;
               SRAM_BWEB = strb_to_bweb(s.S_WStrb);
               addr_d    = addr_inc;
               beat_d    = beat_q + 1'b1;
               // WLAST must coincide with the counted final beat
               if (s.S_WLast != last_beat) begin
                  err_d = 1'b1;
               end
               if (last_beat) begin
                  state_d = WRESP;
               end
            end
         end

         WRESP: begin
            s.S_BValid = 1'b1;
            s.S_BID    = txn_q.id;
            s.S_BResp  = err_q ? RESP_SLVERR : RESP_OKAY;
            if (s.S_BReady) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_slave_wrapper.sv
// Directed self-checking bench for sram_slave_wrapper with a behavioural SRAM.
module tb_sram_slave_wrapper;
   import sram_slave_wrapper_pkg::*;

   localparam int unsigned AW = 14;

   logic              ACLK;
   logic              ARESETn;
   logic              sram_ceb;
   logic              sram_web;
   logic [31:0]       sram_bweb;
   logic [AW-1:0]     sram_a;
   logic [31:0]       sram_di;
   logic [31:0]       sram_do;

   // backdoor preload port of the SRAM model
   logic              bd_we;
   logic [AW-1:0]     bd_addr;
   logic [31:0]       bd_data;

   logic [31:0]       mem [0:(1<<AW)-1];

   int                n_checks;
   int                n_fail;
   logic [31:0]       wr_v [16];
   logic [31:0]       rd_v [16];

   sram_slave_wrapper_if bus ();

   sram_slave_wrapper #(.SRAM_ADDR_BITS(AW)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .s         (bus.slave),
      .SRAM_CEB  (sram_ceb),
      .SRAM_WEB  (sram_web),
      .SRAM_BWEB (sram_bweb),
      .SRAM_A    (sram_a),
      .SRAM_DI   (sram_di),
      .SRAM_DO   (sram_do)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Single-port SRAM, 1-cycle read latency, active-low bit write mask
   always @(posedge ACLK) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (!sram_ceb) begin
         if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
         else           sram_do     <= mem[sram_a];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_bweb(input logic [3:0] strb);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = strb[k] ? 8'h00 : 8'hFF;
      return r;
   endfunction

   task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge ACLK);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge ACLK);
      bd_we = 1'b0;
   endtask

   // Write burst of len+1 beats from wr_v; optionally drop WLAST on the final beat
   task automatic do_write(input logic [31:0] addr, input int len, input logic [7:0] id,
                           input logic [3:0] strb, input bit drop_last,
                           input logic [1:0] exp_resp);
      @(negedge ACLK);
      bus.S_AWValid = 1'b1; bus.S_AWAddr = addr; bus.S_AWLen = 4'(len);
      bus.S_AWID = id; bus.S_AWSize = 3'd2; bus.S_AWBurst = AXI_BURST_INC;
      #1 check("aw_ready", 32'(bus.S_AWReady), 32'd1);
      @(negedge ACLK);
      bus.S_AWValid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         bus.S_WValid = 1'b1; bus.S_WData = wr_v[b]; bus.S_WStrb = strb;
         bus.S_WLast  = (b == len) && !drop_last;
         #1;
         check("w_ready",  32'(bus.S_WReady), 32'd1);
         check("w_ceb",    32'(sram_ceb), 32'd0);
         check("w_web",    32'(sram_web), 32'd0);
         check("w_addr",   32'(sram_a), ((addr >> 2) + 32'(b)) & 32'h3FFF);
         check("w_di",     sram_di, wr_v[b]);
         check("w_bweb",   sram_bweb, exp_bweb(strb));
         @(negedge ACLK);
      end
      bus.S_WValid = 1'b0; bus.S_WLast = 1'b0;
      #1;
      check("b_valid", 32'(bus.S_BValid), 32'd1);
      check("b_id",    32'(bus.S_BID), 32'(id));
      check("b_resp",  32'(bus.S_BResp), 32'(exp_resp));
      bus.S_BReady = 1'b1;
      @(negedge ACLK);
      bus.S_BReady = 1'b0;
      #1 check("b_valid_drop", 32'(bus.S_BValid), 32'd0);
   endtask

   // Read burst expecting rd_v; RReady held low for stall_cycles before beat stall_beat
   task automatic do_read(input logic [31:0] addr, input int len, input logic [7:0] id,
                          input int stall_beat, input int stall_cycles);
      @(negedge ACLK);
      bus.S_ARValid = 1'b1; bus.S_ARAddr = addr; bus.S_ARLen = 4'(len);
      bus.S_ARID = id; bus.S_ARSize = 3'd2; bus.S_ARBurst = AXI_BURST_INC;
      bus.S_RReady = 1'b0;
      #1;
      check("ar_ready", 32'(bus.S_ARReady), 32'd1);
      check("ar_sram_a", 32'(sram_a), (addr >> 2) & 32'h3FFF);
      @(negedge ACLK);
      bus.S_ARValid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         if (b == stall_beat) begin
            bus.S_RReady = 1'b0;
            for (int c = 0; c < stall_cycles; c++) begin
               #1;
               check("r_stall_valid", 32'(bus.S_RValid), 32'd1);
               check("r_stall_data",  bus.S_RData, rd_v[b]);
               @(negedge ACLK);
            end
         end
         bus.S_RReady = 1'b1;
         #1;
         check("r_valid", 32'(bus.S_RValid), 32'd1);
         check("r_data",  bus.S_RData, rd_v[b]);
         check("r_last",  32'(bus.S_RLast), (b == len) ? 32'd1 : 32'd0);
         check("r_id",    32'(bus.S_RID), 32'(id));
         check("r_resp",  32'(bus.S_RResp), 32'd0);
         @(negedge ACLK);
      end
      bus.S_RReady = 1'b0;
      #1 check("r_valid_drop", 32'(bus.S_RValid), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      ARESETn = 1'b0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      bus.S_AWID = '0; bus.S_AWAddr = '0; bus.S_AWLen = '0; bus.S_AWSize = '0;
      bus.S_AWBurst = '0; bus.S_AWValid = 1'b0;
      bus.S_WData = '0; bus.S_WStrb = '0; bus.S_WLast = 1'b0; bus.S_WValid = 1'b0;
      bus.S_BReady = 1'b0;
      bus.S_ARID = '0; bus.S_ARAddr = '0; bus.S_ARLen = '0; bus.S_ARSize = '0;
      bus.S_ARBurst = '0; bus.S_ARValid = 1'b0;
      bus.S_RReady = 1'b0;

      // preload while in reset
      bd_write(14'd4,     32'hDEAD_BEEF);
      bd_write(14'd5,     32'hFFFF_FFFF);
      bd_write(14'h3FFF,  32'h1111_2222);
      bd_write(14'd0,     32'h3333_4444);

      // reset values
      #1;
      check("rst_ar_ready", 32'(bus.S_ARReady), 32'd0);
      check("rst_aw_ready", 32'(bus.S_AWReady), 32'd0);
      check("rst_w_ready",  32'(bus.S_WReady), 32'd0);
      check("rst_b_valid",  32'(bus.S_BValid), 32'd0);
      check("rst_r_valid",  32'(bus.S_RValid), 32'd0);
      check("rst_r_last",   32'(bus.S_RLast), 32'd0);
      check("rst_ceb",      32'(sram_ceb), 32'd1);
      check("rst_web",      32'(sram_web), 32'd1);
      check("rst_bweb",     sram_bweb, 32'hFFFF_FFFF);
      check("rst_sram_a",   32'(sram_a), 32'd0);
      check("rst_di",       sram_di, 32'd0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      #1;
      check("idle_ar_ready", 32'(bus.S_ARReady), 32'd1);
      check("idle_aw_ready", 32'(bus.S_AWReady), 32'd1);

      // single read of word 4
      rd_v[0] = 32'hDEAD_BEEF;
      do_read(32'h0000_0010, 0, 8'h12, -1, 0);

      // 4-beat write to words 8..11, then read back
      wr_v[0] = 32'h0000_00A0; wr_v[1] = 32'h0000_00A1;
      wr_v[2] = 32'h0000_00A2; wr_v[3] = 32'h0000_00A3;
      do_write(32'h0000_0020, 3, 8'h34, 4'hF, 1'b0, RESP_OKAY);
      rd_v[0] = 32'h0000_00A0; rd_v[1] = 32'h0000_00A1;
      rd_v[2] = 32'h0000_00A2; rd_v[3] = 32'h0000_00A3;
      do_read(32'h0000_0020, 3, 8'h56, -1, 0);

      // partial strobe on word 5
      wr_v[0] = 32'h0000_0000;
      do_write(32'h0000_0014, 0, 8'h01, 4'b0101, 1'b0, RESP_OKAY);
      rd_v[0] = 32'hFF00_FF00;
      do_read(32'h0000_0014, 0, 8'h02, -1, 0);

      // read backpressure: 3-cycle stall on beat 1
      rd_v[0] = 32'h0000_00A0; rd_v[1] = 32'h0000_00A1; rd_v[2] = 32'h0000_00A2;
      do_read(32'h0000_0020, 2, 8'h77, 1, 3);

      // simultaneous AR and AW: read first, AW held off until idle
      @(negedge ACLK);
      bus.S_ARValid = 1'b1; bus.S_ARAddr = 32'h20; bus.S_ARLen = 4'd0; bus.S_ARID = 8'h21;
      bus.S_AWValid = 1'b1; bus.S_AWAddr = 32'h40; bus.S_AWLen = 4'd0; bus.S_AWID = 8'h22;
      bus.S_RReady = 1'b0;
      #1;
      check("sim_ar_ready", 32'(bus.S_ARReady), 32'd1);
      check("sim_aw_ready", 32'(bus.S_AWReady), 32'd0);
      @(negedge ACLK);
      bus.S_ARValid = 1'b0; bus.S_RReady = 1'b1;
      #1;
      check("sim_r_valid",   32'(bus.S_RValid), 32'd1);
      check("sim_r_data",    bus.S_RData, 32'h0000_00A0);
      check("sim_r_id",      32'(bus.S_RID), 32'h21);
      check("sim_aw_ready2", 32'(bus.S_AWReady), 32'd0);
      @(negedge ACLK);
      bus.S_RReady = 1'b0;
      #1 check("sim_aw_ready3", 32'(bus.S_AWReady), 32'd1);
      @(negedge ACLK);
      bus.S_AWValid = 1'b0;
      bus.S_WValid = 1'b1; bus.S_WData = 32'h0000_00C0; bus.S_WStrb = 4'hF; bus.S_WLast = 1'b1;
      #1;
      check("sim_w_ready", 32'(bus.S_WReady), 32'd1);
      check("sim_w_addr",  32'(sram_a), 32'd16);
      @(negedge ACLK);
      bus.S_WValid = 1'b0; bus.S_WLast = 1'b0;
      #1;
      check("sim_b_valid", 32'(bus.S_BValid), 32'd1);
      check("sim_b_id",    32'(bus.S_BID), 32'h22);
      check("sim_b_resp",  32'(bus.S_BResp), 32'd0);
      bus.S_BReady = 1'b1;
      @(negedge ACLK);
      bus.S_BReady = 1'b0;
      rd_v[0] = 32'h0000_00C0;
      do_read(32'h0000_0040, 0, 8'h23, -1, 0);

      // missing WLAST on final beat of a 2-beat write
      wr_v[0] = 32'h0000_0B00; wr_v[1] = 32'h0000_0B01;
      do_write(32'h0000_0060, 1, 8'h09, 4'hF, 1'b1, RESP_SLVERR);

      // address wrap from the top word to word 0
      rd_v[0] = 32'h1111_2222; rd_v[1] = 32'h3333_4444;
      do_read(32'h0000_FFFC, 1, 8'h0A, -1, 0);

      // reset in the middle of a write burst
      @(negedge ACLK);
      bus.S_AWValid = 1'b1; bus.S_AWAddr = 32'h80; bus.S_AWLen = 4'd3; bus.S_AWID = 8'h40;
      @(negedge ACLK);
      bus.S_AWValid = 1'b0;
      bus.S_WValid = 1'b1; bus.S_WData = 32'h0000_5555; bus.S_WStrb = 4'hF; bus.S_WLast = 1'b0;
      #1 check("mid_w_ceb", 32'(sram_ceb), 32'd0);
      @(negedge ACLK);
      ARESETn = 1'b0; bus.S_WValid = 1'b0;
      #1;
      check("mid_rst_ceb",      32'(sram_ceb), 32'd1);
      check("mid_rst_w_ready",  32'(bus.S_WReady), 32'd0);
      check("mid_rst_b_valid",  32'(bus.S_BValid), 32'd0);
      check("mid_rst_r_valid",  32'(bus.S_RValid), 32'd0);
      check("mid_rst_ar_ready", 32'(bus.S_ARReady), 32'd0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      #1 check("post_rst_ar_ready", 32'(bus.S_ARReady), 32'd1);
      wr_v[0] = 32'h0000_6666;
      do_write(32'h0000_0080, 0, 8'h41, 4'hF, 1'b0, RESP_OKAY);
      rd_v[0] = 32'h0000_6666;
      do_read(32'h0000_0080, 0, 8'h42, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
